// File: rtl/cim_banked_mem_ctrl.sv
// cim_banked_mem_ctrl
//   Access controller for the CiM banked SRAMs. A flat word address is split
//   into NUM_BANKS banks of BANK_DEPTH words. The controller sequences single
//   and double (two consecutive words) reads and writes, including doubles
//   that straddle a bank boundary. It also tracks the bank read latency and
//   flags out-of-range requests.
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_*_i / req_ready_o    request handshake (addr, write, width, wdata)
//   rsp_valid_o              one-cycle completion pulse
//   rsp_rdata_o, rsp_err_o   read data and error flag (held until next pulse)
//   bank_*_o                 registered one-hot bank enable, we, addr, wdata
//   bank_rdata_i             per-bank read words, bank b at [b*DATA_W +: DATA_W]
module cim_banked_mem_ctrl #(
   parameter  int NUM_BANKS  = 4,
   parameter  int BANK_DEPTH = 14336,
   parameter  int DATA_W     = 9,
   parameter  int RD_LAT     = 1,
   localparam int ADDR_W     = $clog2(NUM_BANKS*BANK_DEPTH),
   localparam int BANK_AW    = $clog2(BANK_DEPTH)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic                          req_write_i,
   input  logic                          req_width_i,
   input  logic [ADDR_W-1:0]             req_addr_i,
   input  logic [2*DATA_W-1:0]           req_wdata_i,
   output logic                          rsp_valid_o,
   output logic [2*DATA_W-1:0]           rsp_rdata_o,
   output logic                          rsp_err_o,
   output logic [NUM_BANKS-1:0]          bank_en_o,
   output logic                          bank_we_o,
   output logic [BANK_AW-1:0]            bank_addr_o,
   output logic [DATA_W-1:0]             bank_wdata_o,
   input  logic [NUM_BANKS*DATA_W-1:0]   bank_rdata_i
);
   localparam int TOTAL = NUM_BANKS*BANK_DEPTH;
   localparam int BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE_LO, ISSUE_HI, WAIT, RESP} state_t;
   state_t state_q, state_d;

   logic                   wr_q, dbl_q;
   logic [BW-1:0]          hi_bank_q, cur_bank_q, cur_bank_d;
   logic [BANK_AW-1:0]     hi_off_q;
   logic [DATA_W-1:0]      wdata_hi_q;
   logic [2*DATA_W-1:0]    dat_q, dat_d;
   logic [NUM_BANKS-1:0]   bank_en_q, bank_en_d;
   logic                   bank_we_q, bank_we_d;
   logic [BANK_AW-1:0]     bank_addr_q, bank_addr_d;
   logic [DATA_W-1:0]      bank_wdata_q, bank_wdata_d;
   logic [2*DATA_W-1:0]    rsp_rdata_q;
   logic                   rsp_err_q;
   logic [RD_LAT-1:0]      tag_vld_q, tag_hi_q;
   logic [RD_LAT-1:0][BW-1:0] tag_bank_q;

   logic                   accept, oob, tag_busy, push, ret;
   logic [31:0]            addr32;
   logic [BW-1:0]          lo_bank, hi_bank;
   logic [BANK_AW-1:0]     lo_off, hi_off;
   logic [DATA_W-1:0]      ret_word;

   assign accept      = req_valid_i & (state_q == IDLE);
   assign req_ready_o = (state_q == IDLE) & rst_ni;
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign bank_en_o   = bank_en_q;
   assign bank_we_o   = bank_we_q;
   assign bank_addr_o = bank_addr_q;
   assign bank_wdata_o = bank_wdata_q;

   // Address decode: compare chain against bank base addresses (no divider).
   always_comb begin
      addr32  = 32'(req_addr_i);
      lo_bank = '0;
      lo_off  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (addr32 >= 32'(b*BANK_DEPTH)) begin
            lo_bank = BW'(b);
            lo_off  = BANK_AW'(addr32 - 32'(b*BANK_DEPTH));
         end
      end
      // hi word rolls into the next bank when lo sits on the last row
      if (lo_off == BANK_AW'(BANK_DEPTH-1)) begin
         hi_bank = lo_bank + BW'(1);
         hi_off  = '0;
      end else begin
         hi_bank = lo_bank;
         hi_off  = lo_off + BANK_AW'(1);
      end
      oob = (addr32 >= 32'(TOTAL)) || (req_width_i && (addr32 == 32'(TOTAL-1)));
   end

   // Any read still in flight other than the one retiring this cycle.
   always_comb begin
      tag_busy = 1'b0;
      for (int i = 0; i < RD_LAT-1; i++) tag_busy = tag_busy | tag_vld_q[i];
   end

   assign push = ((state_q == ISSUE_LO) || (state_q == ISSUE_HI)) && !wr_q;
   assign ret  = tag_vld_q[RD_LAT-1];

   always_comb begin
      ret_word = '0;
      for (int b = 0; b < NUM_BANKS; b++)
         if (tag_bank_q[RD_LAT-1] == BW'(b)) ret_word = bank_rdata_i[b*DATA_W +: DATA_W];
   end

   // Next state, next bank-port values and captured read data.
   always_comb begin
      state_d      = state_q;
      bank_en_d    = '0;
      bank_we_d    = 1'b0;
      bank_addr_d  = '0;
      bank_wdata_d = '0;
      cur_bank_d   = cur_bank_q;
      dat_d        = dat_q;
      if (ret) begin
         if (tag_hi_q[RD_LAT-1]) dat_d[2*DATA_W-1:DATA_W] = ret_word;
         else                    dat_d[DATA_W-1:0]        = ret_word;
      end
      case (state_q)
         IDLE: if (req_valid_i) begin
            dat_d = '0;
            if (oob) state_d = RESP;
            else begin
               state_d      = ISSUE_LO;
               bank_en_d    = NUM_BANKS'(1) << lo_bank;
               bank_we_d    = req_write_i;
               bank_addr_d  = lo_off;
               bank_wdata_d = req_wdata_i[DATA_W-1:0];
               cur_bank_d   = lo_bank;
            end
         end
         ISSUE_LO: begin
            if (dbl_q) begin
               state_d      = ISSUE_HI;
               bank_en_d    = NUM_BANKS'(1) << hi_bank_q;
               bank_we_d    = wr_q;
               bank_addr_d  = hi_off_q;
               bank_wdata_d = wdata_hi_q;
               cur_bank_d   = hi_bank_q;
            end else state_d = wr_q ? RESP : WAIT;
         end
         ISSUE_HI: state_d = wr_q ? RESP : WAIT;
         WAIT:     if (!tag_busy) state_d = RESP;
         RESP:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         wr_q         <= 1'b0;
         dbl_q        <= 1'b0;
         hi_bank_q    <= '0;
         hi_off_q     <= '0;
         wdata_hi_q   <= '0;
         cur_bank_q   <= '0;
         dat_q        <= '0;
         bank_en_q    <= '0;
         bank_we_q    <= 1'b0;
         bank_addr_q  <= '0;
         bank_wdata_q <= '0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         tag_vld_q    <= '0;
         tag_hi_q     <= '0;
         tag_bank_q   <= '0;
      end else begin
         state_q      <= state_d;
         dat_q        <= dat_d;
         cur_bank_q   <= cur_bank_d;
         bank_en_q    <= bank_en_d;
         bank_we_q    <= bank_we_d;
         bank_addr_q  <= bank_addr_d;
         bank_wdata_q <= bank_wdata_d;
         if (accept) begin
            wr_q       <= req_write_i;
            dbl_q      <= req_width_i;
            hi_bank_q  <= hi_bank;
            hi_off_q   <= hi_off;
            wdata_hi_q <= req_wdata_i[2*DATA_W-1:DATA_W];
         end
         for (int i = RD_LAT-1; i > 0; i--) begin
            tag_vld_q[i]  <= tag_vld_q[i-1];
            tag_hi_q[i]   <= tag_hi_q[i-1];
            tag_bank_q[i] <= tag_bank_q[i-1];
         end
         tag_vld_q[0]  <= push;
         tag_hi_q[0]   <= (state_q == ISSUE_HI);
         tag_bank_q[0] <= cur_bank_q;
         // Response registers load on entry to RESP so they are stable
         // during the pulse and hold afterwards.
         if (state_d == RESP) begin
            rsp_err_q   <= (state_q == IDLE);
            rsp_rdata_q <= ((state_q == IDLE) || wr_q) ? '0 : dat_d;
         end
      end
   end
endmodule

// File: tb/tb_cim_banked_mem_ctrl.sv
module tb_cim_banked_mem_ctrl;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;

   // DUT A: default parameters (4 x 14336, RD_LAT=1)
   logic        a_valid = 0, a_write = 0, a_width = 0;
   logic [15:0] a_addr = 0;
   logic [17:0] a_wdata = 0;
   logic        a_req_ready, a_rsp_valid, a_rsp_err, a_bank_we;
   logic [17:0] a_rsp_rdata;
   logic [3:0]  a_bank_en;
   logic [13:0] a_bank_addr;
   logic [8:0]  a_bank_wdata;
   logic [35:0] a_bank_rdata;

   // DUT B: 2 x 15872, RD_LAT=3
   logic        b_valid = 0, b_write = 0, b_width = 0;
   logic [14:0] b_addr = 0;
   logic [17:0] b_wdata = 0;
   logic        b_req_ready, b_rsp_valid, b_rsp_err, b_bank_we;
   logic [17:0] b_rsp_rdata;
   logic [1:0]  b_bank_en;
   logic [13:0] b_bank_addr;
   logic [8:0]  b_bank_wdata;
   logic [17:0] b_bank_rdata;

   cim_banked_mem_ctrl u_a (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(a_valid), .req_ready_o(a_req_ready),
      .req_write_i(a_write), .req_width_i(a_width), .req_addr_i(a_addr), .req_wdata_i(a_wdata),
      .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err),
      .bank_en_o(a_bank_en), .bank_we_o(a_bank_we), .bank_addr_o(a_bank_addr),
      .bank_wdata_o(a_bank_wdata), .bank_rdata_i(a_bank_rdata));

   cim_banked_mem_ctrl #(.NUM_BANKS(2), .BANK_DEPTH(15872), .DATA_W(9), .RD_LAT(3)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(b_valid), .req_ready_o(b_req_ready),
      .req_write_i(b_write), .req_width_i(b_width), .req_addr_i(b_addr), .req_wdata_i(b_wdata),
      .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
      .bank_en_o(b_bank_en), .bank_we_o(b_bank_we), .bank_addr_o(b_bank_addr),
      .bank_wdata_o(b_bank_wdata), .bank_rdata_i(b_bank_rdata));

   // Bank macro models
   logic [8:0] mem_a [0:3][0:14335];
   logic [8:0] rq_a  [0:3];
   logic [8:0] mem_b [0:1][0:15871];
   logic [8:0] p1_b [0:1], p2_b [0:1], p3_b [0:1];

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (a_bank_en[b]) begin
            if (a_bank_we) mem_a[b][a_bank_addr] <= a_bank_wdata;
            else           rq_a[b] <= mem_a[b][a_bank_addr];
         end
      for (int b = 0; b < 2; b++) begin
         if (b_bank_en[b]) begin
            if (b_bank_we) mem_b[b][b_bank_addr] <= b_bank_wdata;
            else           p1_b[b] <= mem_b[b][b_bank_addr];
         end
         p2_b[b] <= p1_b[b];
         p3_b[b] <= p2_b[b];
      end
   end
   assign a_bank_rdata = {rq_a[3], rq_a[2], rq_a[1], rq_a[0]};
   assign b_bank_rdata = {p3_b[1], p3_b[0]};

   int n_run = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Results of the last transaction
   int          lat;
   logic [17:0] rd;
   logic        er;
   logic [3:0]  en_s [1:2];
   logic [13:0] ad_s [1:2];
   logic        we_s [1:2];

   // Issue one request on DUT A (sel=0) or B (sel=1); record bank activity
   // in the first two cycles and the cycle offset of rsp_valid (0 = timeout).
   task automatic run(input bit sel, input logic wr, input logic wd,
                      input logic [15:0] addr, input logic [17:0] wdata);
      @(negedge clk);
      chk("ready", sel ? b_req_ready : a_req_ready, 1);
      if (sel) begin
         b_write = wr; b_width = wd; b_addr = addr[14:0]; b_wdata = wdata; b_valid = 1;
      end else begin
         a_write = wr; a_width = wd; a_addr = addr; a_wdata = wdata; a_valid = 1;
      end
      @(posedge clk); #1;
      a_valid = 0; b_valid = 0;
      lat = 0; rd = '0; er = 0;
      for (int k = 1; k <= 2; k++) begin en_s[k] = '0; ad_s[k] = '0; we_s[k] = 0; end
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         @(negedge clk);
         if (c <= 2) begin
            en_s[c] = sel ? {2'b00, b_bank_en} : a_bank_en;
            ad_s[c] = sel ? b_bank_addr : a_bank_addr;
            we_s[c] = sel ? b_bank_we : a_bank_we;
         end
         if (sel ? b_rsp_valid : a_rsp_valid) begin
            lat = c;
            rd  = sel ? b_rsp_rdata : a_rsp_rdata;
            er  = sel ? b_rsp_err : a_rsp_err;
         end
      end
   endtask

   initial begin
      int pulses;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", a_req_ready, 0);
      chk("rst_en", a_bank_en, 0);
      chk("rst_rsp", a_rsp_valid, 0);
      rst_n = 1;
      @(negedge clk);
      chk("ready_after_rst", a_req_ready, 1);
      chk("rdata_after_rst", a_rsp_rdata, 0);

      // Write single addr 5
      run(0, 1, 0, 16'd5, 18'h001A3);
      chk("ws_en", en_s[1], 4'b0001);
      chk("ws_addr", ad_s[1], 5);
      chk("ws_we", we_s[1], 1);
      chk("ws_en2", en_s[2], 0);
      chk("ws_lat", lat, 2);
      chk("ws_err", er, 0);
      chk("ws_mem", mem_a[0][5], 9'h1A3);

      // Double write straddling banks 0/1
      run(0, 1, 1, 16'd14335, {9'h1AA, 9'h055});
      chk("wd_lat", lat, 3);
      chk("wd_en2", en_s[2], 4'b0010);
      chk("wd_mem_lo", mem_a[0][14335], 9'h055);
      chk("wd_mem_hi", mem_a[1][0], 9'h1AA);

      // Double read across the boundary
      run(0, 0, 1, 16'd14335, 18'h0);
      chk("rd_en1", en_s[1], 4'b0001);
      chk("rd_addr1", ad_s[1], 14335);
      chk("rd_we1", we_s[1], 0);
      chk("rd_en2", en_s[2], 4'b0010);
      chk("rd_addr2", ad_s[2], 0);
      chk("rd_lat", lat, 4);
      chk("rd_data", rd, {9'h1AA, 9'h055});
      chk("rd_err", er, 0);
      // held after the pulse
      @(negedge clk);
      chk("hold_valid", a_rsp_valid, 0);
      chk("hold_data", a_rsp_rdata, {9'h1AA, 9'h055});

      // Single read: upper half zero
      run(0, 0, 0, 16'd5, 18'h0);
      chk("rs_lat", lat, 3);
      chk("rs_data", rd, 18'h001A3);

      // Out of range single
      run(0, 0, 0, 16'd57344, 18'h0);
      chk("oob_en", en_s[1], 0);
      chk("oob_lat", lat, 1);
      chk("oob_err", er, 1);
      chk("oob_data", rd, 0);

      // Double at the last word is out of range; single there is fine
      run(0, 1, 0, 16'd57343, 18'h000FE);
      chk("last_w_en", en_s[1], 4'b1000);
      chk("last_w_addr", ad_s[1], 14335);
      run(0, 0, 1, 16'd57343, 18'h0);
      chk("oobd_lat", lat, 1);
      chk("oobd_err", er, 1);
      run(0, 0, 0, 16'd57343, 18'h0);
      chk("last_r_lat", lat, 3);
      chk("last_r_err", er, 0);
      chk("last_r_data", rd, 18'h000FE);

      // Double within a bank (bank 1 offset 5664/5665)
      run(0, 1, 1, 16'd20000, {9'h101, 9'h0F0});
      run(0, 0, 1, 16'd20000, 18'h0);
      chk("mid_addr1", ad_s[1], 5664);
      chk("mid_addr2", ad_s[2], 5665);
      chk("mid_data", rd, {9'h101, 9'h0F0});

      // DUT B: RD_LAT=3, back-to-back
      run(1, 1, 1, 16'd100, {9'h123, 9'h0AB});
      chk("b_wd_lat", lat, 3);
      run(1, 0, 1, 16'd100, 18'h0);
      chk("b_rd_lat", lat, 6);
      chk("b_rd_data", rd, {9'h123, 9'h0AB});
      run(1, 0, 0, 16'd101, 18'h0);
      chk("b_rs_lat", lat, 5);
      chk("b_rs_data", rd, 18'h00123);

      // Reset mid double read
      run(0, 1, 0, 16'd0, 18'h000C3);
      @(negedge clk);
      a_write = 0; a_width = 1; a_addr = 16'd14335; a_valid = 1;
      @(posedge clk); #1; a_valid = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 0; #1;
      chk("abort_en", a_bank_en, 0);
      chk("abort_we", a_bank_we, 0);
      chk("abort_rsp", a_rsp_valid, 0);
      chk("abort_ready", a_req_ready, 0);
      chk("abort_rdata", a_rsp_rdata, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (a_rsp_valid) pulses++;
      end
      chk("abort_no_rsp", pulses, 0);
      run(0, 0, 0, 16'd0, 18'h0);
      chk("post_lat", lat, 3);
      chk("post_data", rd, 18'h000C3);
      chk("post_err", er, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
